// File: rtl/poly_pkg.sv
// poly_pkg
//   Shared definitions for the Horner polynomial evaluator: the controller
//   state encoding and the upper limits on datapath width and polynomial
//   degree that size the coefficient register file.
package poly_pkg;

    localparam int MAX_WIDTH  = 16;
    localparam int MAX_DEGREE = 7;

    typedef enum logic [2:0] {
        LOAD        = 3'd0,
        LOAD_WAIT   = 3'd1,
        LOAD_X      = 3'd2,
        LOAD_X_WAIT = 3'd3,
        COMPUTE     = 3'd4,
        DONE        = 3'd5,
        DONE_WAIT   = 3'd6
    } state_t;

endpackage

// File: rtl/poly_mac.sv
// poly_mac
//   One Horner step, purely combinational: next_acc = acc*x + coef.
//   Ports:
//     acc      in  WIDTH  running accumulator
//     x        in  WIDTH  evaluation point
//     coef     in  WIDTH  coefficient for this step
//     next_acc out WIDTH  result truncated to WIDTH bits
//     ovf      out 1      any bit above WIDTH-1 of the full result was set
module poly_mac
    import poly_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] coef,
    output logic [WIDTH-1:0] next_acc,
    output logic             ovf
);

    localparam int FULL = 2 * WIDTH + 1;

    // Widened to 2*WIDTH+1 so the product plus carry from the add is never lost.
    logic [FULL-1:0] prod_sum;

    assign prod_sum = FULL'(acc) * FULL'(x) + FULL'(coef);
    assign next_acc = prod_sum[WIDTH-1:0];
    assign ovf      = |prod_sum[FULL-1:WIDTH];

endmodule

// File: rtl/poly_horner.sv
// poly_horner
//   Operator-loaded polynomial evaluator. Coefficients a_DEGREE..a_0 and then
//   x are entered one per go press/release; the result is then computed by
//   Horner's rule in DEGREE cycles.
//   Ports:
//     clk           in  1      clock, rising edge
//     resetn        in  1      synchronous active-low reset
//     go            in  1      load strobe (press/release handshake)
//     data_in       in  WIDTH  coefficient or x value
//     data_result   out WIDTH  y = sum a_i*x^i mod 2^WIDTH
//     result_valid  out 1      data_result holds a completed evaluation
//     overflow      out 1      an intermediate value exceeded WIDTH bits
//     busy          out 1      evaluation in progress, go ignored
module poly_horner
    import poly_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_result,
    output logic             result_valid,
    output logic             overflow,
    output logic             busy
);

    localparam logic [2:0] DEG = 3'(DEGREE);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       k_q, k_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] coef_q [0:MAX_DEGREE];
    logic [WIDTH-1:0] coef_d [0:MAX_DEGREE];
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] mac_next;
    logic             mac_ovf;

    poly_mac #(.WIDTH(WIDTH)) u_mac (
        .acc      (acc_q),
        .x        (x_q),
        .coef     (coef_q[k_q]),
        .next_acc (mac_next),
        .ovf      (mac_ovf)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        k_d      = k_q;
        acc_d    = acc_q;
        x_d      = x_q;
        coef_d   = coef_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            LOAD: begin
                if (go) begin
                    coef_d[idx_q] = data_in;
                    state_d       = LOAD_WAIT;
                end
            end
            // Waiting for release guarantees one capture per press.
            LOAD_WAIT: begin
                if (!go) begin
                    if (idx_q == 3'd0) begin
                        state_d = LOAD_X;
                    end else begin
                        idx_d   = idx_q - 3'd1;
                        state_d = LOAD;
                    end
                end
            end
            LOAD_X: begin
                if (go) begin
                    x_d     = data_in;
                    state_d = LOAD_X_WAIT;
                end
            end
            LOAD_X_WAIT: begin
                if (!go) begin
                    acc_d   = coef_q[DEG];
                    k_d     = DEG - 3'd1;
                    ovf_d   = 1'b0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_d = mac_next;
                ovf_d = ovf_q | mac_ovf;
                if (k_q == 3'd0) begin
                    result_d = mac_next;
                    state_d  = DONE;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            DONE: begin
                if (go) begin
                    state_d = DONE_WAIT;
                end
            end
            DONE_WAIT: begin
                if (!go) begin
                    idx_d   = DEG;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = DEG;
            end
        endcase
    end

    // Status flags are decoded from the next state so they line up with it.
    assign valid_d = (state_d == DONE) || (state_d == DONE_WAIT);
    assign busy_d  = (state_d == COMPUTE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= LOAD;
            idx_q    <= DEG;
            k_q      <= 3'd0;
            acc_q    <= '0;
            x_q      <= '0;
            coef_q   <= '{default: '0};
            result_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result  = result_q;
    assign result_valid = valid_q;
    assign overflow     = ovf_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_poly_horner.sv
// tb_poly_horner
//   Directed bench for poly_horner with two instances: a (WIDTH=8, DEGREE=2)
//   and b (WIDTH=16, DEGREE=3). Expected results come from a software Horner
//   model and are queued when the operand load finishes, then popped when
//   result_valid appears.
module tb_poly_horner;

    typedef struct {
        logic [15:0] result;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        resetn_a, resetn_b;
    logic        go_a, go_b;
    logic [7:0]  din_a;
    logic [15:0] din_b;
    logic [7:0]  res_a;
    logic [15:0] res_b;
    logic        valid_a, valid_b, ovf_a, ovf_b, busy_a, busy_b;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    poly_horner #(.WIDTH(8), .DEGREE(2)) dut_a (
        .clk          (clk),
        .resetn       (resetn_a),
        .go           (go_a),
        .data_in      (din_a),
        .data_result  (res_a),
        .result_valid (valid_a),
        .overflow     (ovf_a),
        .busy         (busy_a)
    );

    poly_horner #(.WIDTH(16), .DEGREE(3)) dut_b (
        .clk          (clk),
        .resetn       (resetn_b),
        .go           (go_b),
        .data_in      (din_b),
        .data_result  (res_b),
        .result_valid (valid_b),
        .overflow     (ovf_b),
        .busy         (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] getResult(input int sel);
        return (sel == 0) ? {8'h00, res_a} : res_b;
    endfunction

    function automatic logic getValid(input int sel);
        return (sel == 0) ? valid_a : valid_b;
    endfunction

    function automatic logic getOvf(input int sel);
        return (sel == 0) ? ovf_a : ovf_b;
    endfunction

    function automatic logic getBusy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    // Reference Horner evaluation with full-precision intermediates.
    function automatic exp_t horner(input int c[8], input int deg, input int x, input int w);
        exp_t        e;
        longint      acc;
        longint      t;
        longint      mask;
        mask  = (64'sd1 <<< w) - 1;
        acc   = longint'(c[deg]);
        e.ovf = 1'b0;
        for (int k = deg - 1; k >= 0; k--) begin
            t = acc * longint'(x) + longint'(c[k]);
            if ((t >>> w) != 0) e.ovf = 1'b1;
            acc = t & mask;
        end
        e.result = 16'(acc);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic setGo(input int sel, input logic v);
        if (sel == 0) go_a = v;
        else          go_b = v;
    endtask

    // One operator press: go held for 'hold' cycles, then one release cycle.
    task automatic applyStimulus(input int sel, input int val, input int hold);
        @(negedge clk);
        if (sel == 0) din_a = 8'(val);
        else          din_b = 16'(val);
        setGo(sel, 1'b1);
        repeat (hold) @(negedge clk);
        setGo(sel, 1'b0);
        @(posedge clk);
    endtask

    task automatic loadPoly(input int sel, input int c[8], input int x, input int hold, input bit push);
        int deg;
        int w;
        deg = (sel == 0) ? 2 : 3;
        w   = (sel == 0) ? 8 : 16;
        for (int i = deg; i >= 0; i--) applyStimulus(sel, c[i], hold);
        applyStimulus(sel, x, hold);
        if (push) sb.push_back(horner(c, deg, x, w));
        @(negedge clk);
    endtask

    // Called at the negedge after the COMPUTE entry edge; counts cycles to valid.
    task automatic waitResult(input int sel, input string tag, input bit toggle);
        int   cycles;
        int   deg;
        exp_t e;
        deg = (sel == 0) ? 2 : 3;
        checkOutput({tag, "_busy"}, 16'(getBusy(sel)), 16'd1);
        cycles = 0;
        while (!getValid(sel) && cycles < 20) begin
            if (toggle) setGo(sel, cycles[0] == 1'b0);
            @(negedge clk);
            cycles++;
        end
        setGo(sel, 1'b0);
        checkOutput({tag, "_latency"}, 16'(cycles), 16'(deg));
        checkOutput({tag, "_valid"}, 16'(getValid(sel)), 16'd1);
        checkOutput({tag, "_busy_done"}, 16'(getBusy(sel)), 16'd0);
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 16'(sb.size()), 16'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_result"}, getResult(sel), e.result);
            checkOutput({tag, "_ovf"}, 16'(getOvf(sel)), 16'(e.ovf));
        end
    endtask

    // Press/release after DONE returns to LOAD; result holds, valid drops.
    task automatic ackDone(input int sel, input string tag, input logic [15:0] held);
        applyStimulus(sel, 0, 1);
        @(negedge clk);
        checkOutput({tag, "_valid_low"}, 16'(getValid(sel)), 16'd0);
        checkOutput({tag, "_result_hold"}, getResult(sel), held);
    endtask

    task automatic checkIdle(input int sel, input string tag);
        checkOutput({tag, "_result"}, getResult(sel), 16'd0);
        checkOutput({tag, "_valid"}, 16'(getValid(sel)), 16'd0);
        checkOutput({tag, "_ovf"}, 16'(getOvf(sel)), 16'd0);
        checkOutput({tag, "_busy"}, 16'(getBusy(sel)), 16'd0);
    endtask

    initial begin
        resetn_a = 1'b0;
        resetn_b = 1'b0;
        go_a     = 1'b0;
        go_b     = 1'b0;
        din_a    = '0;
        din_b    = '0;
        repeat (3) @(negedge clk);
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        checkIdle(0, "rst_a");
        checkIdle(1, "rst_b");

        // 1*x^2 + 2x + 3 at x=4 -> 27
        loadPoly(0, '{3, 2, 1, 0, 0, 0, 0, 0}, 4, 1, 1'b1);
        waitResult(0, "a_27", 1'b0);
        ackDone(0, "a_ack1", 16'd27);

        // 16*x^2 at x=4 -> 256 wraps to 0 with overflow
        loadPoly(0, '{0, 0, 16, 0, 0, 0, 0, 0}, 4, 2, 1'b1);
        waitResult(0, "a_ovf", 1'b0);
        ackDone(0, "a_ack2", 16'd0);

        // 5x + 7 at x=2 -> 17; overflow cleared; go toggling while busy is ignored
        loadPoly(0, '{7, 5, 0, 0, 0, 0, 0, 0}, 2, 1, 1'b1);
        waitResult(0, "a_17", 1'b1);

        // All ones, x=2, long presses -> 15
        loadPoly(1, '{1, 1, 1, 1, 0, 0, 0, 0}, 2, 5, 1'b1);
        waitResult(1, "b_15", 1'b0);
        ackDone(1, "b_ack", 16'd15);

        // Reset during the second COMPUTE cycle; nothing expected from this load
        loadPoly(1, '{9, 8, 7, 6, 0, 0, 0, 0}, 3, 1, 1'b0);
        @(negedge clk);
        resetn_b = 1'b0;
        @(negedge clk);
        resetn_b = 1'b1;
        checkIdle(1, "b_midrst");

        // Fresh load after reset: x^3 at x=3 -> 27
        loadPoly(1, '{0, 0, 0, 1, 0, 0, 0, 0}, 3, 1, 1'b1);
        waitResult(1, "b_27", 1'b0);

        checkOutput("sb_drained", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/poly_horner.md
POLY_HORNER -- requirements
Module: poly_horner

Interface
REQ-001 Parameter WIDTH, default 8: data, coefficient and result width in bits; legal range 4..16.
REQ-002 Parameter DEGREE, default 3: polynomial degree; DEGREE+1 coefficients; legal range 1..7.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset; synchronous, active-low.
REQ-005 go  input  1  operator load strobe, level-sensitive, press/release handshake.
REQ-006 data_in  input  WIDTH  coefficient or x value, unsigned.
REQ-007 data_result  output  WIDTH  y = sum a_i*x^i mod 2^WIDTH, unsigned.
REQ-008 result_valid  output  1  high while data_result holds a completed evaluation.
REQ-009 overflow  output  1  high if any intermediate value of the current evaluation exceeded WIDTH bits.
REQ-010 busy  output  1  high while computing; go is ignored during compute.

Function
REQ-011 States SHALL be LOAD, LOAD_WAIT, LOAD_X, LOAD_X_WAIT, COMPUTE, DONE and DONE_WAIT.
REQ-012 Load order SHALL be a_DEGREE first, down to a_0, then x; coefficient index idx starts at DEGREE.
REQ-013 LOAD: on a cycle with go=1, capture data_in into coef[idx] and go to LOAD_WAIT; otherwise stay.
REQ-014 LOAD_WAIT: stay while go=1; on go=0, decrement idx and return to LOAD, or go to LOAD_X if idx was 0.
REQ-015 LOAD_X: on go=1, capture data_in into x and go to LOAD_X_WAIT; LOAD_X_WAIT on go=0 goes to COMPUTE.
REQ-016 Each value SHALL be captured exactly once per press, however long go is held.
REQ-017 Entering COMPUTE: acc=coef[DEGREE], step counter k=DEGREE-1, overflow cleared.
REQ-018 COMPUTE, each cycle: acc <= (acc*x + coef[k]) truncated to WIDTH; k decrements.
REQ-019 Exit COMPUTE to DONE after the k=0 step; compute latency is exactly DEGREE cycles.
REQ-020 Product and sum SHALL be formed at 2*WIDTH+1 bits; any nonzero bit above WIDTH-1 sets overflow.
REQ-021 overflow is sticky until the next COMPUTE entry or reset.
REQ-022 On the DONE transition, data_result SHALL be loaded from the final acc value.
REQ-023 data_result SHALL hold until the next DONE entry or reset.
REQ-024 result_valid=1 exactly in DONE and DONE_WAIT; busy=1 exactly in COMPUTE.
REQ-025 DONE: go=1 moves to DONE_WAIT; DONE_WAIT on go=0 moves to LOAD with idx=DEGREE, clearing result_valid.
REQ-026 Coefficients not reloaded keep their values; registers are overwritten only by captures.

Reset
REQ-027 resetn=0 at a clock edge SHALL force state LOAD and idx=DEGREE, from any state including mid-COMPUTE.
REQ-028 Reset SHALL clear acc, x, all coefficients, data_result, result_valid, overflow and busy to 0.
REQ-029 The first go press after reset release SHALL capture a_DEGREE.

Structure
REQ-030 Package poly_pkg SHALL hold the state enumeration and the MAX_WIDTH=16 and MAX_DEGREE=7 constants.
REQ-031 Sub-module poly_mac SHALL be combinational: inputs acc, x, coef; outputs truncated next_acc and ovf.
REQ-032 poly_horner SHALL contain the FSM, idx/k counters, coefficient register array and output registers.

Verification
REQ-033 WIDTH=8, DEGREE=2; load a2=1, a1=2, a0=3, x=4 -> after 2 COMPUTE cycles: data_result=27, result_valid=1, overflow=0.
REQ-034 WIDTH=8, DEGREE=2; load a2=16, a1=0, a0=0, x=4 -> data_result=0, overflow=1.
REQ-035 WIDTH=16, DEGREE=3; load all coefficients=1, x=2, go held 5 cycles per press -> data_result=15; exactly 4 coefficient captures plus one x capture.
REQ-036 Assert resetn=0 during the 2nd COMPUTE cycle (DEGREE=3) -> next cycle: state LOAD, all outputs 0; a fresh load of 1,0,0,0 with x=3 -> 27.
REQ-037 After DONE, press/release go, then load a2=0, a1=5, a0=7, x=2 (DEGREE=2) -> result_valid drops on LOAD entry; data_result=17.
REQ-038 go toggled while busy=1 -> no effect on captures or result; latency stays DEGREE cycles.
